// File: rtl/frame_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : frame_scan_pkg
// Brief  : Shared types and default geometry for the frame scan controller.
// Rev    : 1.0  initial release
// ============================================================================
package frame_scan_pkg;

    localparam int DEF_IMAGE_WIDTH  = 320;
    localparam int DEF_IMAGE_HEIGHT = 240;
    localparam int NUM_PIXELS       = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

    // Truncated to the heading width at the point of use.
    localparam logic [31:0] DIR_NONE = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        WRAP   = 3'd3,
        REPORT = 3'd4
    } scan_state_t;

    typedef enum logic {
        OWN_VGA  = 1'b0,
        OWN_SCAN = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/frame_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module : frame_scan_controller_if
// Brief  : VGA, BRAM read port and detector signals of the frame scan controller.
// Rev    : 1.0  initial release
// ============================================================================
interface frame_scan_controller_if #(
    parameter int ADDR_BITS = 17,
    parameter int DIR_BITS  = 6
);
    logic                 frame_ready;
    logic                 vga_req;
    logic [ADDR_BITS-1:0] vga_addr;
    logic [11:0]          vga_rddata;
    logic                 vga_data_valid;
    logic [ADDR_BITS-1:0] bram_rdaddress;
    logic [11:0]          bram_rddata;
    logic [ADDR_BITS-1:0] det_rdaddress;
    logic [11:0]          det_rddata;
    logic                 det_pixel_valid;
    logic [DIR_BITS-1:0]  direction_in;
    logic [DIR_BITS-1:0]  direction;
    logic                 direction_valid;
    logic                 busy;
    logic                 frame_dropped;

    modport master (
        input  frame_ready, vga_req, vga_addr, bram_rddata, direction_in,
        output vga_rddata, vga_data_valid, bram_rdaddress, det_rdaddress,
               det_rddata, det_pixel_valid, direction, direction_valid,
               busy, frame_dropped
    );

    modport slave (
        output frame_ready, vga_req, vga_addr, bram_rddata, direction_in,
        input  vga_rddata, vga_data_valid, bram_rdaddress, det_rdaddress,
               det_rddata, det_pixel_valid, direction, direction_valid,
               busy, frame_dropped
    );
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bram_port_arbiter
// Brief  : Shares one BRAM read port between VGA and the scan, with starvation
//          guard and registered owner tag steering the returned data.
// Rev    : 1.0  initial release
// ============================================================================
module bram_port_arbiter
    import frame_scan_pkg::*;
#(
    parameter int ADDR_BITS    = 17,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 scan_active,
    input  wire logic [ADDR_BITS-1:0] scan_addr,
    input  wire logic                 det_clear,
    input  wire logic                 vga_req,
    input  wire logic [ADDR_BITS-1:0] vga_addr,
    input  wire logic [11:0]          bram_rddata,
    output logic                      scan_grant,
    output logic [ADDR_BITS-1:0]      bram_rdaddress,
    output logic [11:0]               vga_rddata,
    output logic                      vga_data_valid,
    output logic [ADDR_BITS-1:0]      det_rdaddress,
    output logic [11:0]               det_rddata,
    output logic                      det_pixel_valid
);

    localparam int c_STARVE_BITS = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_BITS-1:0] c_STARVE_MAX = c_STARVE_BITS'(STARVE_LIMIT);

    logic [c_STARVE_BITS-1:0] r_starve;
    owner_t                   r_owner;
    logic                     r_vga_valid;
    logic [ADDR_BITS-1:0]     r_det_addr;
    logic                     w_scan_grant;

    // VGA has priority until the scan has been refused STARVE_LIMIT times in a row.
    assign w_scan_grant   = scan_active && (!vga_req || (r_starve == c_STARVE_MAX));
    assign scan_grant     = w_scan_grant;
    assign bram_rdaddress = w_scan_grant ? scan_addr : vga_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve    <= '0;
            r_owner     <= OWN_VGA;
            r_vga_valid <= 1'b0;
            r_det_addr  <= '0;
        end else begin
            if (!scan_active || w_scan_grant) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
            r_owner     <= w_scan_grant ? OWN_SCAN : OWN_VGA;
            r_vga_valid <= vga_req && !w_scan_grant;
            // Held through stalls so the detector only sees address 0 on the wrap.
            if (w_scan_grant) begin
                r_det_addr <= scan_addr;
            end else if (det_clear) begin
                r_det_addr <= '0;
            end
        end
    end

    assign det_pixel_valid = (r_owner == OWN_SCAN);
    assign det_rddata      = det_pixel_valid ? bram_rddata : 12'h000;
    assign det_rdaddress   = r_det_addr;
    assign vga_data_valid  = r_vga_valid;
    assign vga_rddata      = bram_rddata;

endmodule
`default_nettype wire

// File: rtl/frame_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : frame_scan_controller
// Brief  : Runs one raster scan of the frame buffer per captured frame and
//          latches the detector heading with a one-cycle valid strobe.
// Rev    : 1.0  initial release
// ============================================================================
module frame_scan_controller
    import frame_scan_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int FOV          = 25,
    parameter int STARVE_LIMIT = 8,
    parameter int WRAP_CYCLES  = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    frame_scan_controller_if.master bus
);

    localparam int c_NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int c_DIR_BITS   = $clog2(FOV) + 1;
    localparam int c_WRAP_BITS  = (WRAP_CYCLES > 1) ? $clog2(WRAP_CYCLES) : 1;
    localparam logic [ADDR_BITS-1:0]   c_LAST_ADDR = ADDR_BITS'(c_NUM_PIXELS - 1);
    localparam logic [c_WRAP_BITS-1:0] c_WRAP_LAST = c_WRAP_BITS'(WRAP_CYCLES - 1);
    localparam logic [c_DIR_BITS-1:0]  c_DIR_NONE  = DIR_NONE[c_DIR_BITS-1:0];

    scan_state_t             r_state;
    logic [ADDR_BITS-1:0]    r_scan_addr;
    logic                    r_pending;
    logic [c_WRAP_BITS-1:0]  r_wrap_cnt;
    logic [c_DIR_BITS-1:0]   r_direction;
    logic                    r_direction_valid;
    logic                    r_frame_dropped;
    logic                    w_scan_grant;

    bram_port_arbiter #(
        .ADDR_BITS    (ADDR_BITS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .clk             (clk),
        .reset           (reset),
        .scan_active     (r_state == SCAN),
        .scan_addr       (r_scan_addr),
        .det_clear       (r_state == DRAIN),
        .vga_req         (bus.vga_req),
        .vga_addr        (bus.vga_addr),
        .bram_rddata     (bus.bram_rddata),
        .scan_grant      (w_scan_grant),
        .bram_rdaddress  (bus.bram_rdaddress),
        .vga_rddata      (bus.vga_rddata),
        .vga_data_valid  (bus.vga_data_valid),
        .det_rdaddress   (bus.det_rdaddress),
        .det_rddata      (bus.det_rddata),
        .det_pixel_valid (bus.det_pixel_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_scan_addr       <= '0;
            r_pending         <= 1'b0;
            r_wrap_cnt        <= '0;
            r_direction       <= c_DIR_NONE;
            r_direction_valid <= 1'b0;
            r_frame_dropped   <= 1'b0;
        end else begin
            r_direction_valid <= 1'b0;
            r_frame_dropped   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.frame_ready || r_pending) begin
                        r_state     <= SCAN;
                        r_scan_addr <= '0;
                        r_pending   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_scan_grant) begin
                        if (r_scan_addr == c_LAST_ADDR) begin
                            r_state <= DRAIN;
                        end else begin
                            r_scan_addr <= r_scan_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_state    <= WRAP;
                    r_wrap_cnt <= '0;
                end
                WRAP: begin
                    if (r_wrap_cnt == c_WRAP_LAST) begin
                        r_state <= REPORT;
                    end else begin
                        r_wrap_cnt <= r_wrap_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    r_direction       <= bus.direction_in;
                    r_direction_valid <= 1'b1;
                    r_state           <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // One frame of backlog; anything beyond that is reported and dropped.
            if (bus.frame_ready && (r_state != IDLE)) begin
                r_pending <= 1'b1;
                if (r_pending) begin
                    r_frame_dropped <= 1'b1;
                end
            end
        end
    end

    assign bus.direction       = r_direction;
    assign bus.direction_valid = r_direction_valid;
    assign bus.frame_dropped   = r_frame_dropped;
    assign bus.busy            = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_frame_scan_controller
// Brief  : Directed self-checking bench on a 16x4 frame with a BRAM model and
//          a simple leftmost-red-pixel heading model standing in for the detector.
// Rev    : 1.0  initial release
// ============================================================================
module tb_frame_scan_controller;

    localparam int c_W    = 16;
    localparam int c_H    = 4;
    localparam int c_NPIX = c_W * c_H;
    localparam int c_AB   = 6;
    localparam int c_DB   = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    frame_scan_controller_if #(.ADDR_BITS(c_AB), .DIR_BITS(c_DB)) fs_if ();

    frame_scan_controller #(
        .IMAGE_WIDTH  (c_W),
        .IMAGE_HEIGHT (c_H),
        .ADDR_BITS    (c_AB),
        .FOV          (25),
        .STARVE_LIMIT (8),
        .WRAP_CYCLES  (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fs_if)
    );

    always #10 clk = ~clk;

    logic [11:0] mem [0:c_NPIX-1];
    always @(posedge clk) fs_if.bram_rddata <= mem[fs_if.bram_rdaddress];

    // Heading = column of the first red pixel scaled onto 0..25; none -> all-ones.
    logic det_found = 1'b0;
    int   det_x     = 0;
    always @(posedge clk) begin
        if (fs_if.det_pixel_valid) begin
            if (fs_if.det_rdaddress == '0) begin
                det_found <= (fs_if.det_rddata == 12'hF00);
                det_x     <= 0;
            end else if (!det_found && fs_if.det_rddata == 12'hF00) begin
                det_found <= 1'b1;
                det_x     <= int'(fs_if.det_rdaddress) % c_W;
            end
        end
    end
    assign fs_if.direction_in = det_found ? c_DB'(det_x * 25 / (c_W - 1)) : '1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input int red_idx, input logic white);
        for (int i = 0; i < c_NPIX; i++)
            mem[i] = white ? 12'hFFF : ((i == red_idx) ? 12'hF00 : 12'h000);
    endtask

    int st_pix, st_first_pix, st_addr_err, st_gap_err, st_vmiss;
    int st_dv_cnt, st_dv1, st_dv2, st_drop;
    logic [c_DB-1:0] st_dir;

    // Pulses frame_ready, then observes n_cyc cycles; cycle 1 is the first after the pulse edge.
    task automatic run_frame(input int n_cyc, input logic vga_hold, input int gap,
                             input int fr_a, input int fr_b);
        int last_pix = -1;
        st_pix = 0; st_first_pix = -1; st_addr_err = 0; st_gap_err = 0; st_vmiss = 0;
        st_dv_cnt = 0; st_dv1 = -1; st_dv2 = -1; st_drop = 0; st_dir = '0;
        fs_if.vga_req     = vga_hold;
        fs_if.frame_ready = 1'b1;
        @(negedge clk);
        fs_if.frame_ready = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            if (fs_if.det_pixel_valid) begin
                if (int'(fs_if.det_rdaddress) != st_pix % c_NPIX) st_addr_err++;
                if ((st_pix % c_NPIX) != 0 && (c - last_pix) != gap) st_gap_err++;
                if (st_first_pix < 0) st_first_pix = c;
                last_pix = c;
                st_pix++;
            end
            if (vga_hold && (fs_if.vga_data_valid == fs_if.det_pixel_valid)) st_vmiss++;
            if (fs_if.direction_valid) begin
                st_dv_cnt++;
                if (st_dv_cnt == 1) st_dv1 = c; else st_dv2 = c;
                st_dir = fs_if.direction;
            end
            if (fs_if.frame_dropped) st_drop++;
            fs_if.frame_ready = (c == fr_a) || (c == fr_b);
            @(negedge clk);
        end
        fs_if.frame_ready = 1'b0;
        fs_if.vga_req     = 1'b0;
    endtask

    initial begin
        int dv_after_rst;
        fs_if.frame_ready = 1'b0;
        fs_if.vga_req     = 1'b0;
        fs_if.vga_addr    = 6'd7;
        load_mem(15, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_direction", fs_if.direction, 32'h3F);
        check("rst_dir_valid", fs_if.direction_valid, 0);
        check("rst_busy", fs_if.busy, 0);
        check("rst_pix_valid", fs_if.det_pixel_valid, 0);
        check("rst_vga_valid", fs_if.vga_data_valid, 0);
        check("rst_dropped", fs_if.frame_dropped, 0);
        check("rst_det_addr", fs_if.det_rdaddress, 0);
        check("idle_bram_addr", fs_if.bram_rdaddress, 7);

        // Quiet VGA, red at right edge of row 0.
        run_frame(80, 1'b0, 1, -1, -1);
        check("t1_pix_count", st_pix, 64);
        check("t1_first_pix", st_first_pix, 2);
        check("t1_addr_err", st_addr_err, 0);
        check("t1_gap_err", st_gap_err, 0);
        check("t1_dv_count", st_dv_cnt, 1);
        check("t1_dv_cycle", st_dv1, 69);
        check("t1_direction", st_dir, 25);
        check("t1_idle_after", fs_if.busy, 0);

        load_mem(0, 1'b0);
        run_frame(80, 1'b0, 1, -1, -1);
        check("t2_dir_px0", st_dir, 0);
        check("t2_dv_cycle", st_dv1, 69);
        load_mem(22, 1'b0);
        run_frame(80, 1'b0, 1, -1, -1);
        check("t2_dir_px22", st_dir, 10);

        // VGA hogging the port: one forced scan slot every 9 cycles.
        load_mem(15, 1'b0);
        run_frame(600, 1'b1, 9, -1, -1);
        check("t3_pix_count", st_pix, 64);
        check("t3_first_pix", st_first_pix, 10);
        check("t3_gap_err", st_gap_err, 0);
        check("t3_addr_err", st_addr_err, 0);
        check("t3_vga_slots", st_vmiss, 0);
        check("t3_dv_cycle", st_dv1, 581);
        check("t3_direction", st_dir, 25);

        // Two extra frames during SCAN: one pending, one dropped.
        load_mem(0, 1'b0);
        run_frame(150, 1'b0, 1, 10, 20);
        check("t4_dropped", st_drop, 1);
        check("t4_dv_count", st_dv_cnt, 2);
        check("t4_dv1_cycle", st_dv1, 69);
        check("t4_dv2_cycle", st_dv2, 138);
        check("t4_pix_count", st_pix, 128);
        check("t4_addr_err", st_addr_err, 0);

        // Frame arriving in REPORT is queued, not dropped.
        run_frame(150, 1'b0, 1, 68, -1);
        check("t4b_dropped", st_drop, 0);
        check("t4b_dv2_cycle", st_dv2, 138);

        // Reset in the middle of a scan.
        fs_if.frame_ready = 1'b1;
        @(negedge clk);
        fs_if.frame_ready = 1'b0;
        repeat (29) @(negedge clk);
        check("t5_mid_addr", fs_if.det_rdaddress, 28);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_busy", fs_if.busy, 0);
        check("t5_direction", fs_if.direction, 32'h3F);
        check("t5_pix_valid", fs_if.det_pixel_valid, 0);
        dv_after_rst = 0;
        for (int i = 0; i < 100; i++) begin
            if (fs_if.direction_valid) dv_after_rst++;
            @(negedge clk);
        end
        check("t5_no_dv", dv_after_rst, 0);
        load_mem(22, 1'b0);
        run_frame(80, 1'b0, 1, -1, -1);
        check("t5_first_pix", st_first_pix, 2);
        check("t5_addr_err", st_addr_err, 0);
        check("t5_direction", st_dir, 10);

        // All-white frame: no heading.
        load_mem(-1, 1'b1);
        run_frame(80, 1'b0, 1, -1, -1);
        check("t6_dv_count", st_dv_cnt, 1);
        check("t6_direction", st_dir, 32'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
